// File: rtl/l1_mem_pkg.sv
// rtl/l1_mem_pkg.sv - shared constants for the L1 block-memory arbiter and caches
//
// Contents:
//   ADDR_W, DATA_W   default block address / data widths used by the caches
//   arb_state_t      arbiter FSM states (IDLE / GNT_I / GNT_D)
//   REQ_I, REQ_D     requester ids used for the round-robin history bit
package l1_mem_pkg;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } arb_state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/l1_mem_arbiter.sv
// rtl/l1_mem_arbiter.sv - shares one block memory port between the L1 I-cache and D-cache
//
// Grants one cache at a time and holds the grant until the memory's ready
// pulse (or until the granted cache withdraws its request). Memory-side
// outputs are combinational copies of the granted cache's request. Ready and
// read data are returned only to the granted cache. Every transaction costs
// exactly one IDLE cycle of added latency.
//
// Build option: MEM_ARB_RR_EN
//   undefined - fixed priority, D-cache wins a conflict
//   defined   - round-robin on conflict, the requester not granted last wins
//
// Ports:
//   clk, proc_reset                   clock, asynchronous active-high reset
//   i_mem_read/write/addr/wdata       I-cache request
//   i_mem_rdata/ready                 I-cache response
//   d_mem_read/write/addr/wdata       D-cache request
//   d_mem_rdata/ready                 D-cache response
//   mem_read/write/addr/wdata         memory request
//   mem_rdata/ready                   memory response (ready is a 1-cycle pulse)
module l1_mem_arbiter #(
  parameter int ADDR_W = l1_mem_pkg::ADDR_W,
  parameter int DATA_W = l1_mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  import l1_mem_pkg::*;

`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  arb_state_t state_q, state_d;
  logic       last_gnt_q, last_gnt_d;
  logic       i_req, d_req, pick_d;

  assign i_req = i_mem_read | i_mem_write;
  assign d_req = d_mem_read | d_mem_write;

  // Conflict resolution; only consulted in IDLE. With round-robin, the cache
  // that was not served last wins. last_gnt resets to I so D wins first.
  always_comb begin
    pick_d = d_req;
    if (RR_EN && i_req && d_req) begin
      pick_d = (last_gnt_q == REQ_I);
    end
  end

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_mem_ready = 1'b0;
    i_mem_rdata = '0;
    d_mem_ready = 1'b0;
    d_mem_rdata = '0;

    case (state_q)
      IDLE: begin
        // A stray mem_ready here is deliberately dropped.
        if (i_req || d_req) begin
          state_d = pick_d ? GNT_D : GNT_I;
        end
      end

      GNT_I: begin
        mem_read    = i_mem_read;
        mem_write   = i_mem_write;
        mem_addr    = i_mem_addr;
        mem_wdata   = i_mem_wdata;
        i_mem_ready = mem_ready;
        i_mem_rdata = mem_rdata;
        if (mem_ready) begin
          state_d    = IDLE;
          last_gnt_d = REQ_I;
        end else if (!i_req) begin
          // Requester withdrew: abandon without touching the history bit.
          state_d = IDLE;
        end
      end

      GNT_D: begin
        mem_read    = d_mem_read;
        mem_write   = d_mem_write;
        mem_addr    = d_mem_addr;
        mem_wdata   = d_mem_wdata;
        d_mem_ready = mem_ready;
        d_mem_rdata = mem_rdata;
        if (mem_ready) begin
          state_d    = IDLE;
          last_gnt_d = REQ_D;
        end else if (!d_req) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q    <= IDLE;
      last_gnt_q <= REQ_I;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule
